// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: widths, divider FSM states,
// op-select bundle and the fixed result patterns for divide special cases.
package mdu_pkg;

    localparam int XLEN = 64;
    localparam int WLEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

    typedef struct packed {
        logic div;
        logic divu;
        logic rem;
        logic remu;
    } op_sel_t;

    // Quotient returned for any division by zero
    localparam logic [XLEN-1:0] DIV_ZERO_QUOT  = {XLEN{1'b1}};
    // Divisor value (-1) that triggers signed overflow
    localparam logic [XLEN-1:0] NEG_ONE        = {XLEN{1'b1}};
    // Most-negative dividend at 64-bit width and at word width (already sign-extended)
    localparam logic [XLEN-1:0] OVF_DIVIDEND   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] OVF_DIVIDEND_W = {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};

    // Counter value on the final restoring step
    localparam logic [6:0] LAST_STEP   = 7'(XLEN-1);
    localparam logic [6:0] LAST_STEP_W = 7'(WLEN-1);

    function automatic logic [XLEN-1:0] sext_word(input logic [WLEN-1:0] v);
        return {{(XLEN-WLEN){v[WLEN-1]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] zext_word(input logic [WLEN-1:0] v);
        return {{(XLEN-WLEN){1'b0}}, v};
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift remainder:dividend left by one,
// trial-subtract the divisor and keep the difference when it does not borrow.
module div_step
    import mdu_pkg::*;
(
    input  logic [XLEN-1:0] part_rem,
    input  logic [XLEN-1:0] dvd_bits,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] next_rem,
    output logic [XLEN-1:0] next_dvd,
    output logic            quot_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // A set top bit in the shifted remainder already exceeds any divisor, so no borrow is possible
    always_comb begin
        shifted  = {part_rem, dvd_bits[XLEN-1]};
        diff     = shifted - {1'b0, divisor};
        quot_bit = shifted[XLEN] | ~diff[XLEN];
        next_rem = quot_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        next_dvd = {dvd_bits[XLEN-2:0], 1'b0};
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for div/divu/rem/remu and their word
// forms. Divides magnitudes, then fixes signs and word sign-extension at the end.
module div_unit
    import mdu_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            div,
    input  logic            divu,
    input  logic            rem,
    input  logic            remu,
    input  logic            word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    div_state_t      state;
    logic [6:0]      cnt;
    logic [XLEN-1:0] part_rem;
    logic [XLEN-1:0] dvd_bits;
    logic [XLEN-1:0] divisor_abs;
    logic [XLEN-1:0] quotient;
    logic            neg_quot;
    logic            neg_rem;
    logic            sel_rem;
    logic            word_op;

    op_sel_t         op;
    logic            is_signed;
    logic            is_rem;
    logic [XLEN-1:0] dvd_prep;
    logic [XLEN-1:0] dvs_prep;
    logic            dvd_neg;
    logic            dvs_neg;
    logic [XLEN-1:0] dvd_abs;
    logic [XLEN-1:0] dvs_abs;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] special_val;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] dvd_init;

    logic [XLEN-1:0] step_rem;
    logic [XLEN-1:0] step_dvd;
    logic            step_q;

    logic [XLEN-1:0] fix_quot;
    logic [XLEN-1:0] fix_rem;
    logic [XLEN-1:0] fix_sel;
    logic [XLEN-1:0] fix_val;

    // Decode the request and prepare operands; an unsigned select wins over a signed one if both are set
    always_comb begin
        op        = {div, divu, rem, remu};
        is_signed = (op.div | op.rem) & ~(op.divu | op.remu);
        is_rem    = op.rem | op.remu;
        if (word) begin
            dvd_prep = is_signed ? sext_word(src1[WLEN-1:0]) : zext_word(src1[WLEN-1:0]);
            dvs_prep = is_signed ? sext_word(src2[WLEN-1:0]) : zext_word(src2[WLEN-1:0]);
        end else begin
            dvd_prep = src1;
            dvs_prep = src2;
        end
        dvd_neg  = is_signed & dvd_prep[XLEN-1];
        dvs_neg  = is_signed & dvs_prep[XLEN-1];
        dvd_abs  = dvd_neg ? -dvd_prep : dvd_prep;
        dvs_abs  = dvs_neg ? -dvs_prep : dvs_prep;
        div_zero = (dvs_prep == '0);
        overflow = is_signed && (dvs_prep == NEG_ONE)
                   && (dvd_prep == (word ? OVF_DIVIDEND_W : OVF_DIVIDEND));
        if (div_zero) begin
            special_val = is_rem ? dvd_prep : DIV_ZERO_QUOT;
        end else begin
            special_val = is_rem ? '0 : dvd_prep;
        end
        special_res = word ? sext_word(special_val[WLEN-1:0]) : special_val;
        dvd_init    = word ? {dvd_abs[WLEN-1:0], {WLEN{1'b0}}} : dvd_abs;
    end

    div_step u_step (
        .part_rem (part_rem),
        .dvd_bits (dvd_bits),
        .divisor  (divisor_abs),
        .next_rem (step_rem),
        .next_dvd (step_dvd),
        .quot_bit (step_q)
    );

    // Apply sign correction, pick quotient or remainder, and sign-extend word results
    always_comb begin
        fix_quot = neg_quot ? -quotient : quotient;
        fix_rem  = neg_rem ? -part_rem : part_rem;
        fix_sel  = sel_rem ? fix_rem : fix_quot;
        fix_val  = word_op ? sext_word(fix_sel[WLEN-1:0]) : fix_sel;
    end

    // Divider FSM with registered handshake outputs and result
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            part_rem    <= '0;
            dvd_bits    <= '0;
            divisor_abs <= '0;
            quotient    <= '0;
            neg_quot    <= 1'b0;
            neg_rem     <= 1'b0;
            sel_rem     <= 1'b0;
            word_op     <= 1'b0;
            result      <= '0;
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            part_rem  <= '0;
            dvd_bits  <= '0;
            quotient  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (div_zero || overflow) begin
                            result    <= special_res;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            cnt         <= '0;
                            part_rem    <= '0;
                            dvd_bits    <= dvd_init;
                            divisor_abs <= dvs_abs;
                            quotient    <= '0;
                            neg_quot    <= dvd_neg ^ dvs_neg;
                            neg_rem     <= dvd_neg;
                            sel_rem     <= is_rem;
                            word_op     <= word;
                            state       <= CALC;
                        end
                    end
                end
                CALC: begin
                    part_rem <= step_rem;
                    dvd_bits <= step_dvd;
                    quotient <= {quotient[XLEN-2:0], step_q};
                    cnt      <= cnt + 7'd1;
                    if (cnt == (word_op ? LAST_STEP_W : LAST_STEP)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result    <= fix_val;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases, backpressure, flush/reset
// aborts and randomized ops against an arithmetic reference model.
module tb_div_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        div;
    logic        divu;
    logic        rem;
    logic        remu;
    logic        word;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;

    int test_count = 0;
    int fail_count = 0;

    localparam int OP_DIV  = 0;
    localparam int OP_DIVU = 1;
    localparam int OP_REM  = 2;
    localparam int OP_REMU = 3;
    localparam int OP_NONE = 4;

    // Free-running clock
    always #5 clock = ~clock;

    div_unit dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .div       (div),
        .divu      (divu),
        .rem       (rem),
        .remu      (remu),
        .word      (word),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", tag, observed, expected);
        end
    endtask

    // Reference: RISC-V divide semantics computed with plain 64-bit arithmetic
    function automatic void refModel(input int op, input bit w, input logic [63:0] a, input logic [63:0] b,
                                     output logic [63:0] res, output int lat);
        bit          sgn;
        bit          want_rem;
        logic [63:0] ua;
        logic [63:0] ub;
        longint      sa;
        longint      sb;
        logic [63:0] r;
        int          ia;
        int          ib;
        sgn      = (op == OP_DIV) || (op == OP_REM);
        want_rem = (op == OP_REM) || (op == OP_REMU);
        if (w) begin
            ia = a[31:0];
            ib = b[31:0];
            ua = sgn ? 64'(longint'(ia)) : {32'h0, a[31:0]};
            ub = sgn ? 64'(longint'(ib)) : {32'h0, b[31:0]};
        end else begin
            ua = a;
            ub = b;
        end
        sa = longint'(ua);
        sb = longint'(ub);
        if (ub == 64'd0) begin
            r   = want_rem ? ua : 64'hFFFF_FFFF_FFFF_FFFF;
            lat = 1;
        end else if (sgn && sb == -64'sd1 &&
                     ua == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) begin
            r   = want_rem ? 64'd0 : ua;
            lat = 1;
        end else begin
            lat = w ? 34 : 66;
            if (sgn) r = want_rem ? 64'(sa % sb) : 64'(sa / sb);
            else     r = want_rem ? (ua % ub) : (ua / ub);
        end
        if (w) begin
            ia = r[31:0];
            r  = 64'(longint'(ia));
        end
        res = r;
    endfunction

    task automatic setOp(input int op);
        div  = (op == OP_DIV);
        divu = (op == OP_DIVU);
        rem  = (op == OP_REM);
        remu = (op == OP_REMU);
    endtask

    // Wait for in_ready and present one request; returns #1 after the acceptance edge
    task automatic startOp(input int op, input bit w, input logic [63:0] a, input logic [63:0] b);
        int guard;
        guard = 0;
        @(negedge clock);
        while (!in_ready && guard < 300) begin
            @(negedge clock);
            guard++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
        setOp(op);
        word     = w;
        src1     = a;
        src2     = b;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        setOp($urandom_range(0, 3));
        src1     = {$urandom, $urandom};
        src2     = {$urandom, $urandom};
    endtask

    // Issue a request and wait for out_valid; lat counts edges from acceptance inclusive
    task automatic applyStimulus(input int op, input bit w, input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] got, output int lat);
        startOp(op, w, a, b);
        lat = 1;
        while (!out_valid && lat < 300) begin
            @(posedge clock);
            #1;
            lat++;
        end
        if (!out_valid) checkOutput("out_valid_timeout", 64'(out_valid), 64'd1);
        got = result;
    endtask

    task automatic finishHandshake();
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic runCase(input string tag, input int op, input bit w, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] exp_res, input int exp_lat);
        logic [63:0] got;
        int          lat;
        applyStimulus(op, w, a, b, got, lat);
        checkOutput({tag, "_res"}, got, exp_res);
        checkOutput({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        finishHandshake();
    endtask

    function automatic logic [63:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'($urandom_range(1, 20));
            4:       return {32'h0, $urandom};
            5:       return {$urandom, 32'h8000_0000};
            6:       return {$urandom, 32'hFFFF_FFFF};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Main sequence
    initial begin
        logic [63:0] got;
        logic [63:0] exp_res;
        logic [63:0] held;
        int          lat;
        int          exp_lat;
        int          seen;
        int          op;
        bit          w;
        logic [63:0] a;
        logic [63:0] b;

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        word      = 1'b0;
        src1      = '0;
        src2      = '0;
        setOp(OP_NONE);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_result", result, 64'd0);

        runCase("divu_100_7", OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66);
        runCase("remu_100_7", OP_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 66);
        runCase("div_m7_2", OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        runCase("rem_m7_2", OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        runCase("div_5_0", OP_DIV, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        runCase("rem_5_0", OP_REM, 1'b0, 64'd5, 64'd0, 64'd5, 1);
        runCase("div_ovf", OP_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h8000_0000_0000_0000, 1);
        runCase("rem_ovf", OP_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        runCase("divuw_1", OP_DIVU, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34);
        runCase("divw_ovf", OP_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
                64'hFFFF_FFFF_8000_0000, 1);
        runCase("noop_divu", OP_NONE, 1'b0, 64'd1000, 64'd10, 64'd100, 66);

        // Backpressure: result and in_ready must hold while out_ready stays low
        applyStimulus(OP_DIVU, 1'b0, 64'd123456789, 64'd1000, got, lat);
        checkOutput("bp_res", got, 64'd123456);
        held = 64'd123456;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            checkOutput($sformatf("bp_hold_res_%0d", i), result, held);
            checkOutput($sformatf("bp_hold_ready_%0d", i), 64'(in_ready), 64'd0);
            checkOutput($sformatf("bp_hold_valid_%0d", i), 64'(out_valid), 64'd1);
        end
        finishHandshake();
        checkOutput("bp_ready_after", 64'(in_ready), 64'd1);

        // Flush at CALC step 20: aborted op never produces out_valid
        startOp(OP_DIVU, 1'b0, 64'hDEAD_BEEF_0000_1234, 64'd77);
        repeat (19) @(posedge clock);
        #1;
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clock);
            #1;
            if (out_valid) seen = 1;
        end
        checkOutput("flush_no_valid", 64'(seen), 64'd0);
        runCase("divu_9_3", OP_DIVU, 1'b0, 64'd9, 64'd3, 64'd3, 66);

        // Flush together with a request in IDLE drops the request
        @(negedge clock);
        setOp(OP_DIV);
        src1     = 64'd50;
        src2     = 64'd0;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        checkOutput("flush_idle_ready", 64'(in_ready), 64'd1);
        checkOutput("flush_idle_valid", 64'(out_valid), 64'd0);

        // Reset mid-CALC clears the result and returns to IDLE
        startOp(OP_DIVU, 1'b0, 64'd1000, 64'd3);
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        checkOutput("rst_calc_result", result, 64'd0);
        checkOutput("rst_calc_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_calc_valid", 64'(out_valid), 64'd0);
        runCase("post_rst_remu", OP_REMU, 1'b0, 64'd1000, 64'd3, 64'd1, 66);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 4);
            w  = 1'($urandom_range(0, 1));
            a  = pickOperand();
            b  = pickOperand();
            refModel(op, w, a, b, exp_res, exp_lat);
            applyStimulus(op, w, a, b, got, lat);
            checkOutput($sformatf("rnd%0d_op%0d_w%0d_res", i, op, w), got, exp_res);
            checkOutput($sformatf("rnd%0d_op%0d_w%0d_lat", i, op, w), 64'(lat), 64'(exp_lat));
            repeat ($urandom_range(0, 3)) @(posedge clock);
            #1;
            finishHandshake();
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle radix-2 restoring divider for the RV64 M-extension divide and remainder ops: `div`, `divu`, `rem`, `remu` and their word forms. It sits in the execute stage beside the single-cycle combinational multiply/divide unit and takes over all divide and remainder traffic, so no 64-bit combinational divider sits on the critical path. Operands arrive on a valid/ready request port and one 64-bit result leaves on a valid/ready response port. A flush input aborts an in-flight operation on pipeline redirect.

## Interface
- `XLEN`, 64, datapath width; only 64 is supported.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  abort the current operation; takes priority over everything except `reset`.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  high only in IDLE.
- `div`, `divu`, `rem`, `remu`  in  1 each  one-hot op select; sampled when a request is accepted.
- `word`  in  1  selects the 32-bit W form (`divw`, `divuw`, `remw`, `remuw`).
- `src1`  in  64  dividend.
- `src2`  in  64  divisor.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  64  registered result.

## Operation
- FSM has four states: IDLE, CALC, FIX, DONE. Reset and flush both force IDLE with the counter, quotient and remainder registers cleared. `result` resets to 0.
- A request is accepted on an edge where `in_valid && in_ready` is high. Signed = `div|rem`. Remainder select = `rem|remu`.
- Operand preparation for word ops:
  - Operands are the low 32 bits, sign-extended for signed ops and zero-extended for unsigned ops.
  - The iteration count N is 32 for word ops and 64 otherwise.
- Operand preparation for signed ops: absolute values are divided. Quotient is negated if the operand signs differ. Remainder takes the dividend's sign.
- Special cases are resolved at the acceptance edge. The FSM goes IDLE→DONE and skips CALC and FIX.
  - Divisor == 0: quotient is all ones, remainder is the prepared dividend.
  - Signed overflow (dividend = most-negative value, divisor = −1, at the operative width): quotient is the dividend, remainder is 0.
- CALC runs one restoring step per cycle: shift remainder:dividend left by 1, trial-subtract the divisor, set the quotient bit on no-borrow. The counter counts N steps, then the FSM goes to FIX.
- FIX applies sign correction, selects quotient or remainder, and sign-extends bit 31 for word ops. This sign-extension also applies to `divuw` and `remuw`. FIX registers `result` and moves to DONE.
- DONE: `out_valid`=1 and `result` is held stable. On `out_ready` the FSM returns to IDLE. A new request is not accepted in that same cycle.
- Op inputs are ignored outside IDLE. With no op bit set, an accepted request behaves as `divu`. Multiple op bits set is illegal and its behaviour is undefined.

## Timing
- Latency is counted from the acceptance edge to the first cycle with `out_valid` high:
  - 64-bit ops: 66 cycles (1 accept + 64 CALC + 1 FIX).
  - Word ops: 34 cycles.
  - Special cases: 1 cycle.
- Throughput is one op in flight. The next acceptance is possible no earlier than the cycle after the result handshake.
- `out_valid` and `result` hold indefinitely while `out_ready`=0.
- Flush in any state: IDLE on the next edge, no `out_valid` for the aborted op, and `in_ready`=1 in the following cycle. Flush while in DONE also discards the result.
- Flush together with `in_valid` in IDLE: the request is dropped.
- Reset mid-CALC: same as flush, and `result` is cleared to 0.

## Structure
- Shared package `mdu_pkg` holds:
  - `XLEN`;
  - the state enum (IDLE, CALC, FIX, DONE);
  - the op-select bundle;
  - the constants for the divide-by-zero quotient and the overflow patterns.
- Sub-module `div_step` is a purely combinational single restoring iteration. Inputs: partial remainder, dividend bits, divisor. Outputs: next remainder, next dividend bits, quotient bit. It is instantiated once inside `div_unit`.

## Test plan
- `divu` 100 / 7 → `result`=14 after exactly 66 cycles. The same operands with `remu` → 2.
- `div` −7 / 2 → 0xFFFF_FFFF_FFFF_FFFD (−3). `rem` −7 / 2 → 0xFFFF_FFFF_FFFF_FFFF (−1).
- `div` 5 / 0 → 0xFFFF_FFFF_FFFF_FFFF and `rem` 5 / 0 → 5, both with `out_valid` one cycle after acceptance.
- `div` 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000. `rem` with the same operands → 0. Both take 1 cycle.
- `divuw` src1 = 0x1234_5678_FFFF_FFFF, src2 = 1 → 0xFFFF_FFFF_FFFF_FFFF after 34 cycles. `divw` 0x8000_0000 / 0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000.
- Backpressure and flush:
  - Hold `out_ready`=0 for 10 cycles in DONE → `result` stable throughout and `in_ready`=0.
  - Assert `flush` at CALC step 20 → IDLE next edge and `out_valid` never asserted for that op.
  - A subsequent `divu` 9 / 3 → 3.
